// File: rtl/operand_bypass_scoreboard_pkg.sv
// Shared types and defaults for the ID/EX operand bypass and busy scoreboard.
// Latency: n/a (types only). Backpressure: n/a.
// Slot helper gives the LSB of packed slot k of width w.
package operand_bypass_scoreboard_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int RA_W_DEF     = $clog2(NUM_REGS_DEF);

  typedef enum logic [2:0] {
    ZERO,
    EXM,
    MWB,
    CMP,
    RF
  } fwd_src_e;

  function automatic int slot_lsb(input int slot, input int width);
    return slot * width;
  endfunction

endpackage

// File: rtl/operand_fwd_sel.sv
// Per-slot forwarding priority mux: x0, EX/MEM, MEM/WB, completion, regfile.
// Latency: combinational. Backpressure: none, pure function of its inputs.
module operand_fwd_sel
  import operand_bypass_scoreboard_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RA_W = RA_W_DEF
) (
  input  logic [RA_W-1:0] src,
  input  logic [XLEN-1:0] rf_data,
  input  logic            exm_valid,
  input  logic            exm_we,
  input  logic [RA_W-1:0] exm_rd,
  input  logic [XLEN-1:0] exm_data,
  input  logic            mwb_valid,
  input  logic            mwb_we,
  input  logic [RA_W-1:0] mwb_rd,
  input  logic [XLEN-1:0] mwb_data,
  input  logic            cmp_valid,
  input  logic [RA_W-1:0] cmp_rd,
  input  logic [XLEN-1:0] cmp_data,
  output logic [XLEN-1:0] data,
  output fwd_src_e        sel
);

  always_comb begin
    sel  = RF;
    data = rf_data;
    if (src == '0) begin
      sel  = ZERO;
      data = '0;
    end else if (exm_valid && exm_we && (exm_rd == src)) begin
      sel  = EXM;
      data = exm_data;
    end else if (mwb_valid && mwb_we && (mwb_rd == src)) begin
      sel  = MWB;
      data = mwb_data;
    end else if (cmp_valid && (cmp_rd == src)) begin
      sel  = CMP;
      data = cmp_data;
    end
  end

endmodule

// File: rtl/operand_bypass_scoreboard.sv
// Operand bypass, long-latency busy scoreboard, issue stall and stall watchdog.
// Latency: forward/stall combinational, busy visible one cycle after set/clear.
// Backpressure: stall holds ID; optional perf counters behind FWD_PERF_EN.
module operand_bypass_scoreboard
  import operand_bypass_scoreboard_pkg::*;
#(
  parameter  int XLEN     = XLEN_DEF,
  parameter  int NUM_SRC  = 2,
  parameter  int NUM_REGS = NUM_REGS_DEF,
  parameter  int WDOG_CYC = 1024,
  localparam int RA_W     = $clog2(NUM_REGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    iss_valid,
  input  logic [NUM_SRC*RA_W-1:0] iss_src,
  input  logic [NUM_SRC-1:0]      iss_src_en,
  input  logic [RA_W-1:0]         iss_rd,
  input  logic                    iss_we,
  input  logic                    iss_long,
  input  logic [NUM_SRC*RA_W-1:0] ex_src,
  input  logic [NUM_SRC*XLEN-1:0] rf_data,
  input  logic                    exm_valid,
  input  logic                    exm_we,
  input  logic [RA_W-1:0]         exm_rd,
  input  logic [XLEN-1:0]         exm_data,
  input  logic                    mwb_valid,
  input  logic                    mwb_we,
  input  logic [RA_W-1:0]         mwb_rd,
  input  logic [XLEN-1:0]         mwb_data,
  input  logic                    cmp_valid,
  input  logic [RA_W-1:0]         cmp_rd,
  input  logic [XLEN-1:0]         cmp_data,
  output logic [NUM_SRC*XLEN-1:0] fwd_data,
  output logic                    stall,
  output logic [NUM_REGS-1:0]     busy,
  output logic                    hang_err
`ifdef FWD_PERF_EN
  ,
  output logic [31:0]             perf_stall_cyc,
  output logic [31:0]             perf_fwd_exm,
  output logic [31:0]             perf_fwd_mwb,
  output logic [31:0]             perf_fwd_cmp
`endif
);

  localparam int WD_W = $clog2(WDOG_CYC);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(WDOG_CYC - 1);

  fwd_src_e                slot_sel [NUM_SRC];
  logic [NUM_REGS-1:1]     busy_q;
  logic [WD_W-1:0]         wd_cnt;
  logic                    raw_hit;
  logic                    waw_hit;
  logic                    sb_set;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_slot
    operand_fwd_sel #(.XLEN(XLEN), .RA_W(RA_W)) u_sel (
      .src       (ex_src[slot_lsb(k, RA_W) +: RA_W]),
      .rf_data   (rf_data[slot_lsb(k, XLEN) +: XLEN]),
      .exm_valid (exm_valid),
      .exm_we    (exm_we),
      .exm_rd    (exm_rd),
      .exm_data  (exm_data),
      .mwb_valid (mwb_valid),
      .mwb_we    (mwb_we),
      .mwb_rd    (mwb_rd),
      .mwb_data  (mwb_data),
      .cmp_valid (cmp_valid),
      .cmp_rd    (cmp_rd),
      .cmp_data  (cmp_data),
      .data      (fwd_data[slot_lsb(k, XLEN) +: XLEN]),
      .sel       (slot_sel[k])
    );

    a_x0_zero: assert property (@(posedge clk) disable iff (!rst)
      (ex_src[slot_lsb(k, RA_W) +: RA_W] == '0) |-> (slot_sel[k] == ZERO));
  end

  assign busy = {busy_q, 1'b0};

  // A completion landing this cycle releases the RAW; the bypass supplies the value.
  always_comb begin
    raw_hit = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (iss_src_en[k] && busy[iss_src[k*RA_W +: RA_W]] &&
          !(cmp_valid && (cmp_rd == iss_src[k*RA_W +: RA_W])))
        raw_hit = 1'b1;
    end
  end

  assign waw_hit = iss_we && (iss_rd != '0) && busy[iss_rd];
  assign stall   = iss_valid && (raw_hit || waw_hit);
  assign sb_set  = iss_valid && iss_we && iss_long && (iss_rd != '0) && !stall;

  // Set beats clear on the same register: the issuing producer is younger.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (sb_set && (iss_rd == RA_W'(r)))
          busy_q[r] <= 1'b1;
        else if (cmp_valid && (cmp_rd == RA_W'(r)))
          busy_q[r] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt   <= '0;
      hang_err <= 1'b0;
    end else if (!stall) begin
      wd_cnt <= '0;
    end else begin
      if (wd_cnt != WD_MAX)
        wd_cnt <= wd_cnt + 1'b1;
      else
        hang_err <= 1'b1;
    end
  end

`ifdef FWD_PERF_EN
  logic any_exm;
  logic any_mwb;
  logic any_cmp;

  always_comb begin
    any_exm = 1'b0;
    any_mwb = 1'b0;
    any_cmp = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (slot_sel[k] == EXM) any_exm = 1'b1;
      if (slot_sel[k] == MWB) any_mwb = 1'b1;
      if (slot_sel[k] == CMP) any_cmp = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cyc <= '0;
      perf_fwd_exm   <= '0;
      perf_fwd_mwb   <= '0;
      perf_fwd_cmp   <= '0;
    end else begin
      if (stall   && (perf_stall_cyc != '1)) perf_stall_cyc <= perf_stall_cyc + 1'b1;
      if (any_exm && (perf_fwd_exm   != '1)) perf_fwd_exm   <= perf_fwd_exm + 1'b1;
      if (any_mwb && (perf_fwd_mwb   != '1)) perf_fwd_mwb   <= perf_fwd_mwb + 1'b1;
      if (any_cmp && (perf_fwd_cmp   != '1)) perf_fwd_cmp   <= perf_fwd_cmp + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_operand_bypass_scoreboard.sv
// Bench for operand_bypass_scoreboard: forward table, directed stall/watchdog/reset sequences,
// then randomized traffic against a reference model of the busy set and stall run length.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_operand_bypass_scoreboard;

  localparam int XLEN = 32;
  localparam int NS   = 2;
  localparam int NR   = 32;
  localparam int RA_W = 5;
  localparam int WDOG = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              iss_valid;
  logic [NS*RA_W-1:0] iss_src;
  logic [NS-1:0]     iss_src_en;
  logic [RA_W-1:0]   iss_rd;
  logic              iss_we;
  logic              iss_long;
  logic [NS*RA_W-1:0] ex_src;
  logic [NS*XLEN-1:0] rf_data;
  logic              exm_valid, exm_we;
  logic [RA_W-1:0]   exm_rd;
  logic [XLEN-1:0]   exm_data;
  logic              mwb_valid, mwb_we;
  logic [RA_W-1:0]   mwb_rd;
  logic [XLEN-1:0]   mwb_data;
  logic              cmp_valid;
  logic [RA_W-1:0]   cmp_rd;
  logic [XLEN-1:0]   cmp_data;
  logic [NS*XLEN-1:0] fwd_data;
  logic              stall;
  logic [NR-1:0]     busy;
  logic              hang_err;
`ifdef FWD_PERF_EN
  logic [31:0] perf_stall_cyc, perf_fwd_exm, perf_fwd_mwb, perf_fwd_cmp;
`endif

  always #5 clk = ~clk;

  operand_bypass_scoreboard #(.XLEN(XLEN), .NUM_SRC(NS), .NUM_REGS(NR), .WDOG_CYC(WDOG)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_src(iss_src), .iss_src_en(iss_src_en),
    .iss_rd(iss_rd), .iss_we(iss_we), .iss_long(iss_long),
    .ex_src(ex_src), .rf_data(rf_data),
    .exm_valid(exm_valid), .exm_we(exm_we), .exm_rd(exm_rd), .exm_data(exm_data),
    .mwb_valid(mwb_valid), .mwb_we(mwb_we), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .cmp_valid(cmp_valid), .cmp_rd(cmp_rd), .cmp_data(cmp_data),
    .fwd_data(fwd_data), .stall(stall), .busy(busy), .hang_err(hang_err)
`ifdef FWD_PERF_EN
    , .perf_stall_cyc(perf_stall_cyc), .perf_fwd_exm(perf_fwd_exm),
    .perf_fwd_mwb(perf_fwd_mwb), .perf_fwd_cmp(perf_fwd_cmp)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clr();
    iss_valid = 0; iss_src = '0; iss_src_en = '0; iss_rd = '0; iss_we = 0; iss_long = 0;
    ex_src = '0; rf_data = '0;
    exm_valid = 0; exm_we = 0; exm_rd = '0; exm_data = '0;
    mwb_valid = 0; mwb_we = 0; mwb_rd = '0; mwb_data = '0;
    cmp_valid = 0; cmp_rd = '0; cmp_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: set of busy registers and length of the current stall run.
  bit busy_m [NR];
  bit hang_m;
  int run_m;

  function automatic logic [31:0] fwd_ref(input logic [4:0] s, input logic [31:0] rf);
    if (s == 0) return 32'h0;
    if (exm_valid && exm_we && exm_rd == s) return exm_data;
    if (mwb_valid && mwb_we && mwb_rd == s) return mwb_data;
    if (cmp_valid && cmp_rd == s) return cmp_data;
    return rf;
  endfunction

  function automatic bit stall_ref();
    bit st;
    logic [4:0] s;
    st = 0;
    if (!iss_valid) return 0;
    for (int k = 0; k < NS; k++) begin
      s = iss_src[k*RA_W +: RA_W];
      if (iss_src_en[k] && busy_m[s] && !(cmp_valid && cmp_rd == s)) st = 1;
    end
    if (iss_we && iss_rd != 0 && busy_m[iss_rd]) st = 1;
    return st;
  endfunction

  function automatic logic [31:0] busy_vec();
    logic [31:0] v;
    v = '0;
    for (int r = 0; r < NR; r++) v[r] = busy_m[r];
    return v;
  endfunction

  typedef struct {
    logic [4:0]  s0, s1;
    logic [31:0] rf0, rf1;
    logic        exm_v, exm_w;
    logic [4:0]  exm_r;
    logic [31:0] exm_d;
    logic        mwb_v, mwb_w;
    logic [4:0]  mwb_r;
    logic [31:0] mwb_d;
    logic        cmp_v;
    logic [4:0]  cmp_r;
    logic [31:0] cmp_d;
    logic [31:0] e0, e1;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [31:0] e0, e1;
    bit st;

    tbl[0] = '{5'd5, 5'd6, 32'h11, 32'h2222, 1, 1, 5'd5, 32'hAAAA0000, 1, 1, 5'd5, 32'h1234,
               0, 5'd0, 32'h0, 32'hAAAA0000, 32'h2222};
    tbl[1] = '{5'd3, 5'd0, 32'h3333, 32'h4444, 1, 1, 5'd0, 32'hFFFFFFFF, 0, 0, 5'd0, 32'h0,
               0, 5'd0, 32'h0, 32'h3333, 32'h0};
    tbl[2] = '{5'd8, 5'd9, 32'h1, 32'h2, 1, 0, 5'd8, 32'h1, 1, 1, 5'd8, 32'hBEEF,
               1, 5'd9, 32'hC0DE, 32'hBEEF, 32'hC0DE};
    tbl[3] = '{5'd10, 5'd10, 32'h5, 32'h6, 0, 1, 5'd10, 32'hDEAD, 1, 0, 5'd10, 32'hF00D,
               1, 5'd10, 32'h77, 32'h77, 32'h77};
    tbl[4] = '{5'd12, 5'd13, 32'hA, 32'hB, 1, 1, 5'd14, 32'hE, 1, 1, 5'd15, 32'hF,
               1, 5'd16, 32'h10, 32'hA, 32'hB};
    tbl[5] = '{5'd15, 5'd0, 32'h7, 32'h8, 0, 0, 5'd0, 32'h0, 1, 1, 5'd15, 32'h1515,
               1, 5'd15, 32'h9999, 32'h1515, 32'h0};

    clr();
    rst = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    #1;
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_hang", 64'(hang_err), 64'h0);
    chk("rst_stall", 64'(stall), 64'h0);
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      ex_src    = {tbl[i].s1, tbl[i].s0};
      rf_data   = {tbl[i].rf1, tbl[i].rf0};
      exm_valid = tbl[i].exm_v; exm_we = tbl[i].exm_w; exm_rd = tbl[i].exm_r; exm_data = tbl[i].exm_d;
      mwb_valid = tbl[i].mwb_v; mwb_we = tbl[i].mwb_w; mwb_rd = tbl[i].mwb_r; mwb_data = tbl[i].mwb_d;
      cmp_valid = tbl[i].cmp_v; cmp_rd = tbl[i].cmp_r; cmp_data = tbl[i].cmp_d;
      #1;
      chk($sformatf("tbl%0d_slot0", i), 64'(fwd_data[31:0]), 64'(tbl[i].e0));
      chk($sformatf("tbl%0d_slot1", i), 64'(fwd_data[63:32]), 64'(tbl[i].e1));
      tick();
    end

    // Load-use: long producer on r7, consumer stalls until completion.
    clr();
    iss_valid = 1; iss_we = 1; iss_long = 1; iss_rd = 7;
    #1 chk("lu_issue_stall", 64'(stall), 64'h0);
    tick();
    clr();
    iss_valid = 1; iss_src = 10'd7; iss_src_en = 2'b01;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("lu_stall%0d", i), 64'(stall), 64'h1);
      if (i == 0) chk("lu_busy7", 64'(busy), 64'h80);
      tick();
    end
    cmp_valid = 1; cmp_rd = 7; cmp_data = 32'h55; ex_src = 10'd7; rf_data = {32'h0, 32'hBAD};
    #1;
    chk("lu_release_stall", 64'(stall), 64'h0);
    chk("lu_cmp_fwd", 64'(fwd_data[31:0]), 64'h55);
    tick();
    clr();
    #1 chk("lu_busy_clear", 64'(busy), 64'h0);

    // Same-cycle set and clear on r9, then WAW to r9.
    iss_valid = 1; iss_we = 1; iss_long = 1; iss_rd = 9; cmp_valid = 1; cmp_rd = 9;
    #1 chk("sc_stall", 64'(stall), 64'h0);
    tick();
    clr();
    #1 chk("sc_busy9", 64'(busy), 64'h200);
    iss_valid = 1; iss_we = 1; iss_rd = 9;
    #1 chk("sc_waw_stall", 64'(stall), 64'h1);
    iss_rd = 0;
    #1 chk("sc_x0_no_stall", 64'(stall), 64'h0);
    tick();
    clr();
    cmp_valid = 1; cmp_rd = 9;
    tick();
    clr();
    #1 chk("sc_busy_clear", 64'(busy), 64'h0);

    // Watchdog: permanent RAW on r3.
    iss_valid = 1; iss_we = 1; iss_long = 1; iss_rd = 3;
    tick();
    clr();
    iss_valid = 1; iss_src = 10'd3; iss_src_en = 2'b01;
    for (int i = 0; i < WDOG; i++) begin
      #1 chk($sformatf("wd_stall%0d", i), 64'(stall), 64'h1);
      tick();
      #1 chk($sformatf("wd_hang_after%0d", i + 1), 64'(hang_err), 64'(i == WDOG - 1));
    end
    clr();
    cmp_valid = 1; cmp_rd = 3;
    tick();
    clr();
    #1;
    chk("wd_hang_sticky", 64'(hang_err), 64'h1);
    chk("wd_stall_gone", 64'(stall), 64'h0);

    // Async reset with busy = {4,7}.
    iss_valid = 1; iss_we = 1; iss_long = 1; iss_rd = 4;
    tick();
    iss_rd = 7;
    tick();
    clr();
    #1 chk("ar_busy_pre", 64'(busy), 64'h90);
    #1 rst = 0;
    #1;
    chk("ar_busy", 64'(busy), 64'h0);
    chk("ar_hang", 64'(hang_err), 64'h0);
`ifdef FWD_PERF_EN
    chk("ar_perf", {perf_stall_cyc | perf_fwd_exm, perf_fwd_mwb | perf_fwd_cmp}, 64'h0);
`endif
    cmp_valid = 1; cmp_rd = 4;
    tick();
    rst = 1;
    clr();
    #1 chk("ar_busy_post", 64'(busy), 64'h0);
    tick();

    // Randomized traffic against the reference model.
    for (int r = 0; r < NR; r++) busy_m[r] = 0;
    hang_m = 0;
    run_m  = 0;
    for (int c = 0; c < 800; c++) begin
      iss_valid  = 1'($urandom_range(0, 1));
      iss_src    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      iss_src_en = 2'($urandom_range(0, 3));
      iss_rd     = 5'($urandom_range(0, 7));
      iss_we     = 1'($urandom_range(0, 1));
      iss_long   = 1'($urandom_range(0, 1));
      ex_src     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      rf_data    = {$urandom, $urandom};
      exm_valid  = 1'($urandom_range(0, 1)); exm_we = 1'($urandom_range(0, 1));
      exm_rd     = 5'($urandom_range(0, 7)); exm_data = $urandom;
      mwb_valid  = 1'($urandom_range(0, 1)); mwb_we = 1'($urandom_range(0, 1));
      mwb_rd     = 5'($urandom_range(0, 7)); mwb_data = $urandom;
      cmp_valid  = ($urandom_range(0, 9) < 4);
      cmp_rd     = 5'($urandom_range(0, 7)); cmp_data = $urandom;
      #1;
      st = stall_ref();
      e0 = fwd_ref(ex_src[4:0], rf_data[31:0]);
      e1 = fwd_ref(ex_src[9:5], rf_data[63:32]);
      chk("rnd_stall", 64'(stall), 64'(st));
      chk("rnd_fwd", 64'(fwd_data), {e1, e0});
      chk("rnd_busy", 64'(busy), 64'(busy_vec()));
      chk("rnd_hang", 64'(hang_err), 64'(hang_m));
      @(posedge clk);
      if (cmp_valid && cmp_rd != 0) busy_m[cmp_rd] = 0;
      if (iss_valid && iss_we && iss_long && iss_rd != 0 && !st) busy_m[iss_rd] = 1;
      run_m = st ? run_m + 1 : 0;
      if (run_m >= WDOG) hang_m = 1;
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
